// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs RATIO narrow stream beats into one wide FIFO word
// tagged with {last, valid-lane count minus 1}, and holds the word in place
// while the FIFO is full.
// Optional feature: define FIFO_WR_PACKER_TIMEOUT_EN to auto-flush a partial
// word after TIMEOUT idle cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_FILL | output slot empty; beats collect in the lane registers
// ST_PEND | output word valid; HOLD while fifo_full (nothing accepted),
//         | DRAIN while !fifo_full (write, may load the next word)
module fifo_wr_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int TIMEOUT   = 64,
    localparam int CNT_W     = $clog2(RATIO),
    localparam int OUT_WIDTH = IN_WIDTH * RATIO + CNT_W + 1
) (
    input  logic                 rst_async,
    input  logic                 wr_clk,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] fifo_din,
    output logic                 fifo_wr_en,
    input  logic                 fifo_full,
    output logic                 idle,
    output logic [15:0]          pkt_count
);

    localparam int LANE_W = IN_WIDTH * RATIO;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_idx;
    logic [LANE_W-1:0]      r_lanes;
    logic [LANE_W-1:0]      w_lanes_next;
    logic [OUT_WIDTH-1:0]   r_out_word;
    logic [OUT_WIDTH-1:0]   w_word;
    logic [15:0]            r_pkt_count;
    logic                   w_ready;
    logic                   w_wr_en;
    logic                   w_accept;
    logic                   w_flush_req;
    logic                   w_tmo_hit;
    logic                   w_beat_done;
    logic                   w_flush_nobeat;
    logic                   w_load;
    logic [CNT_W-1:0]       w_cnt;

`ifdef FIFO_WR_PACKER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Idle-cycle down-counter; reloads on any beat or emission, fires at zero
    always_ff @(posedge wr_clk or posedge rst_async) begin
        if (rst_async) begin
            r_tmo_cnt <= '0;
        end else if (w_load || w_accept || (r_idx == '0)) begin
            r_tmo_cnt <= TMO_W'(TIMEOUT - 1);
        end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
        end
    end

    assign w_tmo_hit = (r_idx != '0) && (r_tmo_cnt == '0);
`else
    // No auto-flush; TIMEOUT stays referenced but the term is always false
    assign w_tmo_hit = 1'b0 & (TIMEOUT < 0);
`endif

    assign w_flush_req = flush | w_tmo_hit;

    // Lane file with the current beat dropped into lane r_idx
    always_comb begin
        w_lanes_next = r_lanes;
        for (int i = 0; i < RATIO; i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_lanes_next[i*IN_WIDTH +: IN_WIDTH] = s_data;
            end
        end
    end

    // Handshake, completion decode and next-state
    always_comb begin
        w_state_next   = r_state;
        w_ready        = 1'b1;
        w_wr_en        = 1'b0;
        w_accept       = 1'b0;
        w_beat_done    = 1'b0;
        w_flush_nobeat = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_ready = 1'b1;
                w_wr_en = 1'b0;
            end
            ST_PEND: begin
                w_ready = !fifo_full;
                w_wr_en = !fifo_full;
            end
            default: begin
                w_ready = 1'b0;
                w_wr_en = 1'b0;
            end
        endcase
        w_accept       = s_valid && w_ready;
        w_beat_done    = w_accept &&
                         ((r_idx == CNT_W'(RATIO - 1)) || s_last || w_flush_req);
        w_flush_nobeat = !w_accept && w_flush_req && (r_idx != '0) && w_ready;
        w_load         = w_beat_done || w_flush_nobeat;
        if (w_load) begin
            w_state_next = ST_PEND;
        end else if (w_wr_en) begin
            w_state_next = ST_FILL;
        end
    end

    // Word assembled from either the completing beat or the held partial lanes
    always_comb begin
        w_cnt  = w_accept ? r_idx : (r_idx - CNT_W'(1));
        w_word = {(w_accept & s_last), w_cnt,
                  (w_accept ? w_lanes_next : r_lanes)};
    end

    // State register
    always_ff @(posedge wr_clk or posedge rst_async) begin
        if (rst_async) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accumulator: lane index and lane file, cleared when a word is emitted
    always_ff @(posedge wr_clk or posedge rst_async) begin
        if (rst_async) begin
            r_idx   <= '0;
            r_lanes <= '0;
        end else if (w_load) begin
            r_idx   <= '0;
            r_lanes <= '0;
        end else if (w_accept) begin
            r_idx   <= r_idx + 1'b1;
            r_lanes <= w_lanes_next;
        end
    end

    // Output word register; only changes when a new word loads
    always_ff @(posedge wr_clk or posedge rst_async) begin
        if (rst_async) begin
            r_out_word <= '0;
        end else if (w_load) begin
            r_out_word <= w_word;
        end
    end

    // Packet counter: one per written word carrying the last flag
    always_ff @(posedge wr_clk or posedge rst_async) begin
        if (rst_async) begin
            r_pkt_count <= '0;
        end else if (w_wr_en && r_out_word[OUT_WIDTH-1]) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    assign s_ready    = w_ready;
    assign fifo_wr_en = w_wr_en;
    assign fifo_din   = r_out_word;
    assign idle       = (r_idx == '0) && (r_state == ST_FILL);
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer (IN_WIDTH=8, RATIO=4, TIMEOUT=8).
module tb_fifo_wr_packer;

    logic        rst_async;
    logic        wr_clk;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        flush;
    logic [34:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        idle;
    logic [15:0] pkt_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [34:0] wr_q[$];

    fifo_wr_packer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(8)) dut (
        .rst_async (rst_async),
        .wr_clk    (wr_clk),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .flush     (flush),
        .fifo_din  (fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full (fifo_full),
        .idle      (idle),
        .pkt_count (pkt_count)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Every word written to the FIFO, captured mid-cycle
    always @(negedge wr_clk) begin
        if (fifo_wr_en) wr_q.push_back(fifo_din);
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int k;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        k = 0;
        @(negedge wr_clk);
        while (!s_ready && k < 50) begin
            @(negedge wr_clk);
            k++;
        end
        if (!s_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_beat_timeout: s_ready=%b required 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge wr_clk);
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
        n_tests++; if (fifo_din !== 35'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", fifo_din); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_tests++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        tick();
    endtask

    task automatic test_aligned();
        wr_q.delete();
        for (int i = 1; i <= 8; i++) send_beat(8'(i), (i == 8));
        repeat (3) tick();
        n_tests++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL aligned_count: got %0d want 2", wr_q.size()); end
        n_tests++; if (wr_q[0] !== {1'b0, 2'd3, 32'h04030201}) begin n_fail++; $display("FAIL aligned_word1: got %h want %h", wr_q[0], {1'b0, 2'd3, 32'h04030201}); end
        n_tests++; if (wr_q[1] !== {1'b1, 2'd3, 32'h08070605}) begin n_fail++; $display("FAIL aligned_word2: got %h want %h", wr_q[1], {1'b1, 2'd3, 32'h08070605}); end
        n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL aligned_pkt_count: got %0d want 1", pkt_count); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL aligned_idle: got %b want 1", idle); end
    endtask

    task automatic test_partial_last();
        wr_q.delete();
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        @(negedge wr_clk);
        n_tests++; if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL partial_latency: wr_en got %b want 1", fifo_wr_en); end
        n_tests++; if (fifo_din !== {1'b1, 2'd1, 32'h0000BBAA}) begin n_fail++; $display("FAIL partial_word: got %h want %h", fifo_din, {1'b1, 2'd1, 32'h0000BBAA}); end
        repeat (2) tick();
        n_tests++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL partial_count: got %0d want 1", wr_q.size()); end
        n_tests++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL partial_pkt_count: got %0d want 2", pkt_count); end
    endtask

    task automatic test_backpressure();
        wr_q.delete();
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(8'h11 + 8'(i), 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h21;
        s_last  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge wr_clk);
            n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold_wr_en c%0d: got %b want 0", c, fifo_wr_en); end
            n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready c%0d: got %b want 0", c, s_ready); end
            n_tests++; if (fifo_din !== {1'b0, 2'd3, 32'h14131211}) begin n_fail++; $display("FAIL bp_hold_din c%0d: got %h want %h", c, fifo_din, {1'b0, 2'd3, 32'h14131211}); end
            tick();
        end
        fifo_full = 1'b0;
        @(negedge wr_clk);
        n_tests++; if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL bp_release_wr_en: got %b want 1", fifo_wr_en); end
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", s_ready); end
        tick();
        s_valid = 1'b0;
        send_beat(8'h22, 1'b0);
        send_beat(8'h23, 1'b0);
        send_beat(8'h24, 1'b1);
        repeat (3) tick();
        n_tests++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", wr_q.size()); end
        n_tests++; if (wr_q[0] !== {1'b0, 2'd3, 32'h14131211}) begin n_fail++; $display("FAIL bp_word1: got %h want %h", wr_q[0], {1'b0, 2'd3, 32'h14131211}); end
        n_tests++; if (wr_q[1] !== {1'b1, 2'd3, 32'h24232221}) begin n_fail++; $display("FAIL bp_word2: got %h want %h", wr_q[1], {1'b1, 2'd3, 32'h24232221}); end
        n_tests++; if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL bp_pkt_count: got %0d want 3", pkt_count); end
    endtask

    task automatic test_flush();
        wr_q.delete();
        send_beat(8'h31, 1'b0);
        send_beat(8'h32, 1'b0);
        send_beat(8'h33, 1'b0);
        repeat (2) tick();
        n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL flush_pre_idle: got %b want 0", idle); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge wr_clk);
        n_tests++; if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL flush_wr_en: got %b want 1", fifo_wr_en); end
        n_tests++; if (fifo_din !== {1'b0, 2'd2, 32'h00333231}) begin n_fail++; $display("FAIL flush_word: got %h want %h", fifo_din, {1'b0, 2'd2, 32'h00333231}); end
        tick();
        @(negedge wr_clk);
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL flush_post_idle: got %b want 1", idle); end
        tick();
        flush = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        repeat (2) tick();
        n_tests++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL flush_idle_nowrite: writes got %0d want 1", wr_q.size()); end
        n_tests++; if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL flush_pkt_count: got %0d want 3", pkt_count); end
    endtask

    task automatic test_reset_midop();
        wr_q.delete();
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(8'h51 + 8'(i), 1'b1 && (i == 3));
        @(negedge wr_clk);
        n_tests++; if (fifo_din !== {1'b1, 2'd3, 32'h54535251}) begin n_fail++; $display("FAIL rst_pending_word: got %h want %h", fifo_din, {1'b1, 2'd3, 32'h54535251}); end
        #2;
        rst_async = 1'b1;
        #1;
        n_tests++; if (fifo_din !== 35'h0) begin n_fail++; $display("FAIL rst_mid_din: got %h want 0", fifo_din); end
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", s_ready); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle: got %b want 1", idle); end
        n_tests++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_pkt_count: got %0d want 0", pkt_count); end
        tick();
        fifo_full = 1'b0;
        rst_async = 1'b0;
        repeat (4) tick();
        n_tests++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_nowrite: writes got %0d want 0", wr_q.size()); end
        send_beat(8'h41, 1'b0);
        send_beat(8'h42, 1'b0);
        @(negedge wr_clk);
        #2;
        rst_async = 1'b1;
        #1;
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_lanes_idle: got %b want 1", idle); end
        tick();
        rst_async = 1'b0;
        tick();
        send_beat(8'h71, 1'b0);
        send_beat(8'h72, 1'b1);
        repeat (3) tick();
        n_tests++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL rst_after_count: got %0d want 1", wr_q.size()); end
        n_tests++; if (wr_q[0] !== {1'b1, 2'd1, 32'h00007271}) begin n_fail++; $display("FAIL rst_after_word: got %h want %h", wr_q[0], {1'b1, 2'd1, 32'h00007271}); end
        n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL rst_after_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_timeout();
        int first_wr;
        wr_q.delete();
        first_wr = 0;
        send_beat(8'h81, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge wr_clk);
            if (fifo_wr_en && first_wr == 0) first_wr = c;
            tick();
        end
`ifdef FIFO_WR_PACKER_TIMEOUT_EN
        n_tests++; if (first_wr !== 9) begin n_fail++; $display("FAIL timeout_cycle: first write at idle cycle %0d want 9", first_wr); end
        n_tests++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL timeout_count: got %0d want 1", wr_q.size()); end
        n_tests++; if (wr_q[0] !== {1'b0, 2'd0, 32'h00000081}) begin n_fail++; $display("FAIL timeout_word: got %h want %h", wr_q[0], {1'b0, 2'd0, 32'h00000081}); end
`else
        n_tests++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL timeout_off_nowrite: got %0d want 0 (first at %0d)", wr_q.size(), first_wr); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        n_tests++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL timeout_off_flush_count: got %0d want 1", wr_q.size()); end
        n_tests++; if (wr_q[0] !== {1'b0, 2'd0, 32'h00000081}) begin n_fail++; $display("FAIL timeout_off_word: got %h want %h", wr_q[0], {1'b0, 2'd0, 32'h00000081}); end
`endif
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL timeout_idle: got %b want 1", idle); end
    endtask

    initial begin
        rst_async = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_last    = 1'b0;
        flush     = 1'b0;
        fifo_full = 1'b0;
        repeat (3) tick();
        rst_async = 1'b0;
        tick();
        test_reset();
        test_aligned();
        test_partial_last();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side producer for the dual-clock FIFO, in the `wr_clk` domain. It accepts a narrow valid/ready stream with packet framing and packs `RATIO` input beats into one wide FIFO word tagged with a valid-lane count and a last flag. It drives the FIFO write port (`din`/`wr_en`/`full`) and holds data in place, without dropping it, while the FIFO is full.

## Interface
- `IN_WIDTH`, 8, input beat width in bits.
- `RATIO`, 4, beats per FIFO word; power of two, ≥2.
- `TIMEOUT`, 64, idle cycles before auto-flush; used only with the configuration macro.
- Derived: `CNT_W = $clog2(RATIO)`; `OUT_WIDTH = IN_WIDTH*RATIO + CNT_W + 1`.
- `rst_async`  in  1  reset, asynchronous, active-high.
- `wr_clk`  in  1  clock.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_data`  in  `IN_WIDTH`  input beat.
- `s_last`  in  1  final beat of packet.
- `flush`  in  1  level request to emit a partial word.
- `fifo_din`  out  `OUT_WIDTH`  packed word to the FIFO.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_full`  in  1  FIFO full flag.
- `idle`  out  1  no partial data and no pending word.
- `pkt_count`  out  16  packets written to the FIFO; wraps.

## Operation
- Packed word layout:
  - `[IN_WIDTH*RATIO-1:0]` holds the lanes, lane 0 in the LSBs.
  - Next `CNT_W` bits hold the valid-lane count minus 1.
  - MSB is the last flag.
  - Unused lanes are zero.
- Accumulator: lane register file plus lane index `idx` (`CNT_W` bits, reset 0). Each accepted beat is written to lane `idx`.
- Output register: `out_word` and `out_valid`. `fifo_din = out_word`; `fifo_wr_en = out_valid && !fifo_full`.
- `s_ready = !out_valid || !fifo_full`. The output slot is free or drains this cycle.
- A word completes on an accepted beat when any of these holds:
  - `idx == RATIO-1`;
  - `s_last`;
  - `flush` is high in the same cycle.
- On completion: the word moves to `out_word`, `out_valid` is set, `idx` returns to 0 and lanes clear. The last flag equals `s_last` of the completing beat.
- Flush without a beat: if `flush` is high, `idx > 0`, no beat is accepted and the slot is free (same condition as `s_ready`), the partial word is emitted with last flag 0.
- Flush with `idx == 0` and no beat is a no-op.
- `flush` is level: it acts in the first cycle the slot is free.
- `out_valid` clears on `fifo_wr_en` unless a new word loads the same cycle.
- `idle = (idx == 0) && !out_valid`.
- `pkt_count` increments on `fifo_wr_en` when the last flag of `out_word` is set.
- States:
  - FILL (`!out_valid`);
  - HOLD (`out_valid && fifo_full`): accepts nothing;
  - DRAIN (`out_valid && !fifo_full`): writes and may load the next word in the same cycle.

## Timing
- Reset values: `s_ready`=1, `fifo_wr_en`=0, `fifo_din`=0, `idle`=1, `pkt_count`=0. `idx`, lanes, `out_valid` and the timeout counter are all 0.
- Latency: a completing beat accepted at cycle N gives `fifo_wr_en` at N+1 if `fifo_full`=0 at N+1.
- Throughput: one beat per cycle sustained while the FIFO is not full; back-to-back FIFO writes every `RATIO` cycles.
- Full: `fifo_din` is stable while held. `s_ready` falls combinationally with `fifo_full` while `out_valid` is set.
- Reset mid-operation: partial lanes and the pending word are discarded, and no write is issued.
- Handshake: `s_data`, `s_last` and `flush` are sampled only when `s_valid && s_ready`, except the no-beat flush case above.

## Configuration
- `FIFO_WR_PACKER_TIMEOUT_EN` defined:
  - A counter counts cycles with `idx > 0` and no accepted beat; it resets on an accepted beat or on emission.
  - Reaching `TIMEOUT` acts as an internal `flush`: partial word emitted with last flag 0.
- Undefined: no counter; partial words are held until `s_last`, a full word, or `flush`. `TIMEOUT` is ignored.

## Test plan
- Aligned packet:
  - Stimulus: `RATIO`=4, 8 beats 0x01..0x08 with `s_last` on beat 8, `fifo_full`=0.
  - Response: two writes. Word 1 has data 0x04030201, cnt 3, last 0. Word 2 has data 0x08070605, cnt 3, last 1. `pkt_count`=1.
- Partial last:
  - Stimulus: 2 beats 0xAA, 0xBB with `s_last` on beat 2.
  - Response: one write with data 0x0000BBAA, cnt 1, last 1, one cycle after beat 2.
- Backpressure:
  - Stimulus: hold `fifo_full`=1 after 4 beats.
  - Response: `fifo_wr_en`=0 and `fifo_din` stable. `s_ready`=0 until `fifo_full`=0, then exactly one write and no beat lost or duplicated.
- Flush:
  - Stimulus: 3 beats without `s_last`, idle 2 cycles, pulse `flush`.
  - Response: word with cnt 2, last 0. `idle`=1 afterwards. `flush` with `idle`=1 gives no write.
- Reset mid-operation:
  - Stimulus: assert `rst_async` with 2 lanes filled and a pending word under full.
  - Response: no write. All outputs at reset values within the same cycle.
- Timeout (macro defined):
  - Stimulus: `TIMEOUT`=8, 1 beat, then idle.
  - Response: partial word with cnt 0, last 0 written after 8 idle cycles. Macro undefined: no write.
